// File: rtl/serial_add_ctrl.sv
// Bit-serial add/sub controller: one full-adder cell reused LSB-first
// over WIDTH cycles, with start/busy/done handshake and registered flags.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);
  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [CW-1:0]    cnt;
  logic             cy_q;
  logic             cin_msb;
  logic             s;
  logic             cout;
  logic [WIDTH-1:0] sum_next;

  full_adder u_fa (
    .A   (a_sh[0]),
    .B   (b_sh[0]),
    .Cin (cy_q),
    .S   (s),
    .Cout(cout)
  );

  assign sum_next = {s, sum_sh[WIDTH-1:1]};
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      cnt      <= '0;
      cy_q     <= 1'b0;
      cin_msb  <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh   <= op_a;
            b_sh   <= sub ? ~op_b : op_b;
            cy_q   <= sub;
            cnt    <= '0;
            sum_sh <= '0;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_next;
          cy_q   <= cout;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            // carry into the MSB is cy_q on this cycle
            cin_msb  <= cy_q;
            result   <= sum_next;
            carry    <= cout;
            overflow <= cy_q ^ cout;
            zero     <= (sum_next == '0);
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
